// File: rtl/dcp_tx_fmt.sv
// dcp_tx_fmt: UART (8N1, LSB first) transmit back end for the debug command
// processors. Sends either one raw byte or a 32-bit word rendered as eight
// uppercase ASCII hex digits, MSB nibble first, then pulses ack_tx.
module dcp_tx_fmt #(
    parameter int unsigned DIV = 868
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_tx,
    input  logic        type_tx,
    input  logic [31:0] din_tx,
    output logic        ack_tx,
    output logic        busy,
    output logic        txd
);

    localparam int unsigned TMR_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BITS  = 3'd2,
        S_STOP  = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t              state_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [2:0]          bit_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CHAR_W-1:0]   sh_q;
    logic                type_q;
    logic [DATA_W-1:0]   data_q;

    logic                tick;
    logic [NIB_W-1:0]    nib;
    logic [CHAR_W-1:0]   char_sel;

    // End of one bit period
    assign tick = (tmr_q == TMR_W'(DIV - 1));

    // Character for the current index: raw low byte, or the selected nibble as ASCII hex
    always_comb begin
        nib      = NIB_W'(data_q >> (5'd28 - {idx_q, 2'b00}));
        char_sel = data_q[CHAR_W-1:0];
        if (type_q) begin
            if (nib < NIB_W'(10)) begin
                char_sel = 8'h30 + {4'h0, nib};
            end else begin
                char_sel = 8'h37 + {4'h0, nib};
            end
        end
    end

    // Frame sequencer with registered line, busy and ack outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            type_q  <= 1'b0;
            data_q  <= '0;
            txd     <= 1'b1;
            ack_tx  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack_tx <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                    if (req_tx) begin
                        type_q  <= type_tx;
                        data_q  <= din_tx;
                        idx_q   <= '0;
                        tmr_q   <= '0;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    if (tick) begin
                        tmr_q   <= '0;
                        bit_q   <= '0;
                        txd     <= char_sel[0];
                        sh_q    <= {1'b0, char_sel[CHAR_W-1:1]};
                        state_q <= S_BITS;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_BITS: begin
                    if (tick) begin
                        tmr_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd     <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd   <= sh_q[0];
                            sh_q  <= {1'b0, sh_q[CHAR_W-1:1]};
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        tmr_q <= '0;
                        if (type_q && (idx_q != IDX_W'(7))) begin
                            idx_q   <= idx_q + IDX_W'(1);
                            txd     <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            ack_tx  <= 1'b1;
                            state_q <= S_ACK;
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_ACK: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    txd     <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcp_tx_fmt.sv
// Bench for dcp_tx_fmt: driver pushes expected chars and ack times into
// queues; a line monitor decodes UART frames and an ack monitor checks timing.
module tb_dcp_tx_fmt;

    localparam int DIV = 4;
    localparam int FRAME = 10 * DIV;

    logic        clk;
    logic        rstn;
    logic        req_tx;
    logic        type_tx;
    logic [31:0] din_tx;
    logic        ack_tx;
    logic        busy;
    logic        txd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_chars[$];
    int         exp_acks[$];

    dcp_tx_fmt #(.DIV(DIV)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req_tx  (req_tx),
        .type_tx (type_tx),
        .din_tx  (din_tx),
        .ack_tx  (ack_tx),
        .busy    (busy),
        .txd     (txd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the characters a request puts on the line
    task automatic push_exp(input bit t, input logic [31:0] d, input int n);
        if (!t) begin
            if (n > 0) exp_chars.push_back(d[7:0]);
        end else begin
            for (int i = 0; i < n; i++) begin
                int nv;
                nv = int'((d >> (28 - 4 * i)) & 32'hF);
                if (nv < 10) exp_chars.push_back(8'(48 + nv));
                else         exp_chars.push_back(8'(65 + nv - 10));
            end
        end
    endtask

    // Present a request; returns at the first sample after the acceptance edge
    task automatic accept(input bit t, input logic [31:0] d, input int n_exp,
                          input bit exp_ack, output int e0);
        @(negedge clk);
        req_tx  = 1'b1;
        type_tx = t;
        din_tx  = d;
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        push_exp(t, d, n_exp);
        if (exp_ack) exp_acks.push_back(e0 + FRAME * (t ? 8 : 1));
        chk("accept_line", {30'd0, busy, txd}, 32'h2);
    endtask

    // Wait for ack with a cycle budget, then release the request
    task automatic wait_ack(output int a);
        int n;
        n = 0;
        while (ack_tx !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            errors++;
            checks++;
            $display("FAIL ack_timeout: no ack_tx within %0d cycles", n);
        end
        req_tx = 1'b0;
        a = cyc;
    endtask

    // Line and ack monitor
    int         pos = -1;
    logic [7:0] rx;
    bit         frame_ok;
    always @(negedge clk) begin
        if (!rstn) begin
            pos = -1;
        end else if (pos < 0) begin
            if (txd === 1'b0) begin
                pos = 0;
                frame_ok = 1'b1;
                rx = 8'h00;
            end
        end else begin
            pos++;
            if (pos == 1 && txd !== 1'b0) frame_ok = 1'b0;
            if (pos >= 5 && pos <= 33 && ((pos - 5) % 4) == 0) rx = {txd, rx[7:1]};
            if (pos == 37) begin
                if (txd !== 1'b1) frame_ok = 1'b0;
                if (exp_chars.size() == 0) begin
                    chk("unexpected_frame", {24'd0, rx}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_chars.pop_front();
                    chk("frame_char", {23'd0, frame_ok, rx}, {23'd0, 1'b1, e});
                end
            end
            if (pos == 39) pos = -1;
        end

        if (rstn && ack_tx === 1'b1) begin
            if (exp_acks.size() == 0) begin
                chk("unexpected_ack", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                int ea;
                ea = exp_acks.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(ea));
                chk("busy_at_ack", {31'd0, busy}, 32'h1);
            end
        end
    end

    initial begin
        int e0;
        int a;
        rstn    = 1'b0;
        req_tx  = 1'b0;
        type_tx = 1'b0;
        din_tx  = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {29'd0, ack_tx, busy, txd}, 32'h1);
        rstn = 1'b1;

        // Idle with no request
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_outputs", {29'd0, ack_tx, busy, txd}, 32'h1);
        end

        // Raw byte, upper bits ignored
        accept(1'b0, 32'hFFFF_FF44, 1, 1'b1, e0);
        wait_ack(a);

        // Hex words
        accept(1'b1, 32'h1234_ABCD, 8, 1'b1, e0);
        wait_ack(a);
        accept(1'b1, 32'h0000_0009, 8, 1'b1, e0);
        wait_ack(a);

        // Payload changes after acceptance have no effect
        accept(1'b1, 32'hDEAD_BEEF, 8, 1'b1, e0);
        type_tx = 1'b0;
        din_tx  = 32'h0;
        wait_ack(a);

        // Requester drops req during char 3; word still completes
        accept(1'b1, 32'hC0FF_EE42, 8, 1'b1, e0);
        repeat (3 * FRAME + 10) @(negedge clk);
        req_tx = 1'b0;
        wait_ack(a);
        accept(1'b0, 32'h0000_003A, 1, 1'b1, e0);
        chk("accept_after_ack", 32'(e0), 32'(a + 2));
        wait_ack(a);

        // Reset during the data bits of char 5
        accept(1'b1, 32'h8765_4321, 5, 1'b0, e0);
        repeat (5 * FRAME + 10) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("async_reset", {30'd0, busy, txd}, 32'h1);
        req_tx = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_no_ack", {31'd0, ack_tx}, 32'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        accept(1'b0, 32'h0000_000A, 1, 1'b1, e0);
        wait_ack(a);

        // Randomized requests
        for (int k = 0; k < 12; k++) begin
            bit          t;
            logic [31:0] d;
            t = 1'($urandom % 2);
            d = $urandom;
            accept(t, d, t ? 8 : 1, 1'b1, e0);
            wait_ack(a);
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (50) @(negedge clk);
        chk("chars_pending", 32'(exp_chars.size()), 32'd0);
        chk("acks_pending", 32'(exp_acks.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcp_tx_fmt.md
# dcp_tx_fmt

Serial transmit back end for the debug command processors. Accepts one request at a time on the processor-side tx handshake (`req_tx` / `type_tx` / `din_tx` / `ack_tx`) and sends it out on a UART line (8N1, LSB first). A request is either a single raw byte or a 32-bit word. A word is rendered as 8 uppercase ASCII hex digits. The block sits between the command-processor request mux and the board TXD pin.

## Interface
- `DIV`, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_tx`  in  1  request. The requester holds it high until it sees `ack_tx`, then drops it.
- `type_tx`  in  1  0 = send `din_tx[7:0]` raw; 1 = send `din_tx` as 8 hex characters.
- `din_tx`  in  32  payload. It is sampled only on the acceptance edge.
- `ack_tx`  out  1  single-cycle completion pulse.
- `busy`  out  1  high whenever the block is not in IDLE.
- `txd`  out  1  UART serial output; idle level is 1.

## Operation
- States:
  - **IDLE**
    - Outputs: `txd`=1, `busy`=0.
    - If `req_tx`=1: latch `type_tx` and `din_tx`, set char index to 0, go to START.
  - **START**
    - `txd`=0 for DIV cycles, then go to BITS.
  - **BITS**
    - Shift out the current char LSB first, DIV cycles per bit.
    - After 8 bits, go to STOP.
  - **STOP**
    - `txd`=1 for DIV cycles.
    - Then, if type=1 and index<7: increment index and go to START.
    - Otherwise go to ACK.
  - **ACK**
    - `ack_tx`=1 for exactly one cycle, then go to IDLE.
- Char selection:
  - type=0: the char is `din_tx[7:0]`. Bits [31:8] are ignored.
  - type=1: index i selects nibble n = word[31-4i -: 4], so the MSB nibble is sent first.
  - Nibble 0–9 maps to 0x30+n; nibble A–F maps to 0x37+n (uppercase).
- Counters:
  - Bit timer counts 0..DIV-1.
  - Bit counter is 3 bits.
  - Char index is 3 bits and never wraps past 7 within a request.
- The requester drives payload combinationally, so only latched values are used after acceptance. Changes on `din_tx` or `type_tx` mid-transfer have no effect.
- `req_tx` is ignored outside IDLE. Dropping `req_tx` mid-transfer does not abort the transfer: the current byte or word completes and `ack_tx` still pulses.
- `req_tx` still high in the IDLE cycle after ACK is accepted as a new request. Conforming requesters have already dropped it by then.
- Reset, including mid-frame: all state returns to IDLE immediately.
  - Reset values: `txd`=1, `ack_tx`=0, `busy`=0. Latched payload and all counters are cleared.
  - No partial frame resumes after reset.

## Timing
- All outputs are registered.
- Let E0 be the edge that samples `req_tx`=1 in IDLE.
  - `txd` falls and `busy` rises at E0.
  - Each char frame is 10·DIV cycles.
  - Chars of one word are back to back, with no idle bits between a stop bit and the next start bit.
- For a request of C chars (C=1 or 8), `ack_tx` is high from edge E0+10·DIV·C for one cycle. `busy` stays high through that cycle.
- The earliest next acceptance edge is E0+10·DIV·C+2 (the first IDLE cycle after ACK).
- Latency from request to line activity is 1 edge.
- Throughput:
  - Raw bytes: one byte per 10·DIV+2 cycles.
  - Words: one word per 80·DIV+2 cycles.

## Test plan
All scenarios use DIV=4.
- **Reset and idle:** rstn=0, then 1. Hold `req_tx`=0 for 100 cycles → `txd`=1, `busy`=0, `ack_tx`=0 throughout.
- **Raw byte:** type=0, din=0xFFFFFF44 → `txd` per bit period is 0,0,0,1,0,0,0,1,0,1 (start, LSB-first 0x44, stop). `ack_tx` is a 1-cycle pulse 40 cycles after acceptance, and exactly one ack is produced.
- **Hex word:** type=1, din=0x1234ABCD → chars 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44 sent contiguously over 320 cycles, then a single `ack_tx`. Repeat with 0x00000009 → 0x30 ×7, then 0x39.
- **Payload stability:** accept type=1, din=0xDEADBEEF, then change din to 0 and type to 0 in the next cycle → line still carries "DEADBEEF" in 8 frames.
- **Requester drop mid-transfer:** deassert `req_tx` during char 3 of a word → all 8 chars are sent and `ack_tx` pulses. Then a conforming request (req held until ack) for 0x3A is accepted 2 cycles after ack and sent correctly.
- **Reset mid-frame:** assert rstn=0 during the BITS state of char 5 → `txd`=1 and `busy`=0 asynchronously, and no ack is produced. After release, a type=0 request with 0x0A transmits a clean frame.
